// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcode/funct constants,
// ALU operation encodings and the per-instruction control bundle.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  // Control bundle carried down the pipe; EX fields first, then MEM, then WB.
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
    logic    ra_write;
    logic    mul;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_ZERO = '0;

  function automatic logic [5:0] ex_bits(input ctrl_bundle_t c);
    return {c.reg_dst, c.alu_src, c.alu_op, c.ra_write, c.mul};
  endfunction

  function automatic logic [1:0] mem_bits(input ctrl_bundle_t c);
    return {c.mem_read, c.mem_write};
  endfunction

  function automatic logic [1:0] wb_bits(input ctrl_bundle_t c);
    return {c.reg_write, c.mem_to_reg};
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Pure combinational ID-stage decoder: control bundle, destination register
// and the control-transfer / source-usage flags used by the hazard logic.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int RA_REG = 31
) (
  input  logic [5:0]      op_i,
  input  logic [5:0]      funct_i,
  input  logic [RA_W-1:0] rt_i,
  input  logic [RA_W-1:0] rd_i,
  output ctrl_bundle_t    ctrl_o,
  output logic [RA_W-1:0] dst_o,
  output logic            jump_o,
  output logic            jump_r_o,
  output logic            beq_o,
  output logic            use_rt_o
);

  localparam logic [RA_W-1:0] RA_DST = RA_W'(RA_REG);

  // Instruction decode table; instructions that write nothing report dst 0.
  always_comb begin
    ctrl_o   = CTRL_ZERO;
    dst_o    = '0;
    jump_o   = 1'b0;
    jump_r_o = 1'b0;
    beq_o    = 1'b0;
    use_rt_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.alu_op    = ALU_RTYPE;
        ctrl_o.reg_write = 1'b1;
        dst_o            = rd_i;
        use_rt_o         = 1'b1;
        case (funct_i)
          FN_JR: begin
            jump_r_o         = 1'b1;
            ctrl_o.reg_write = 1'b0;
            dst_o            = '0;
          end
          FN_JALR: begin
            jump_r_o        = 1'b1;
            ctrl_o.ra_write = 1'b1;
            dst_o           = RA_DST;
          end
          FN_MULT: begin
            ctrl_o.mul       = 1'b1;
            ctrl_o.reg_write = 1'b0;
            dst_o            = '0;
          end
          default: begin
            dst_o = rd_i;
          end
        endcase
      end
      OP_BEQ: begin
        ctrl_o.alu_op = ALU_SUB;
        beq_o         = 1'b1;
        use_rt_o      = 1'b1;
      end
      OP_J: begin
        jump_o = 1'b1;
      end
      OP_JAL: begin
        jump_o           = 1'b1;
        ctrl_o.ra_write  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        dst_o            = RA_DST;
      end
      OP_LW: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        dst_o             = rt_i;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        use_rt_o         = 1'b1;
      end
      default: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALU_ITYPE;
        dst_o            = rt_i;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control and hazard unit for the 5-stage MIPS core.
// Optional build macro PIPE_CTRL_FORWARD_EN adds fwd_a/fwd_b forwarding
// selects and relaxes the RAW stall to load-use and branch-operand hazards.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int RA_W    = 5,
  parameter int RA_REG  = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      id_op,
  input  logic [5:0]      id_funct,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic [RA_W-1:0] id_rd,
  input  logic            eq,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            if_flush,
  output logic            pc_src,
  output logic            jump,
  output logic            jump_r,
  output logic [5:0]      ex_ctrl,
  output logic [1:0]      mem_ctrl,
  output logic [1:0]      wb_ctrl,
  output logic [RA_W-1:0] ex_dst,
  output logic [RA_W-1:0] mem_dst,
  output logic [RA_W-1:0] wb_dst,
  output logic            mul_busy
`ifdef PIPE_CTRL_FORWARD_EN
  ,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
`endif
);

  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  ctrl_bundle_t    id_ctrl;
  logic [RA_W-1:0] id_dst;
  logic            id_jump, id_jump_r, id_beq, id_use_rt;

  ctrl_bundle_t    ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0] ex_dst_q, ex_dst_d;
  logic [1:0]      mem_ctrl_q, mem_ctrl_d;
  logic [1:0]      mem_wb_q, mem_wb_d;
  logic [RA_W-1:0] mem_dst_q, mem_dst_d;
  logic [1:0]      wb_ctrl_q, wb_ctrl_d;
  logic [RA_W-1:0] wb_dst_q, wb_dst_d;
  logic [3:0]      mul_cnt_q, mul_cnt_d;
`ifdef PIPE_CTRL_FORWARD_EN
  logic [RA_W-1:0] ex_rs_q, ex_rs_d;
  logic [RA_W-1:0] ex_rt_q, ex_rt_d;
`endif

  logic mul_stall, hz_stall, load_use, br_haz, raw_haz;
  logic ex_nz, mem_nz, ex_rs_m, ex_rt_m, mem_rs_m, mem_rt_m, is_br;

  ctrl_decode #(
    .RA_W   (RA_W),
    .RA_REG (RA_REG)
  ) u_decode (
    .op_i     (id_op),
    .funct_i  (id_funct),
    .rt_i     (id_rt),
    .rd_i     (id_rd),
    .ctrl_o   (id_ctrl),
    .dst_o    (id_dst),
    .jump_o   (id_jump),
    .jump_r_o (id_jump_r),
    .beq_o    (id_beq),
    .use_rt_o (id_use_rt)
  );

  // Hazard detection: compare ID sources against EX and MEM destinations.
  always_comb begin
    mul_stall = (mul_cnt_q != 4'd0);
    ex_nz     = (ex_dst_q != '0);
    mem_nz    = (mem_dst_q != '0);
    ex_rs_m   = (ex_dst_q == id_rs);
    ex_rt_m   = (ex_dst_q == id_rt);
    mem_rs_m  = (mem_dst_q == id_rs);
    mem_rt_m  = (mem_dst_q == id_rt);
    is_br     = id_beq | id_jump_r;
    load_use  = ex_ctrl_q.mem_read & ex_nz & (ex_rs_m | (id_use_rt & ex_rt_m));
    br_haz    = is_br & (
                  (ex_ctrl_q.reg_write & ex_nz & (ex_rs_m | (id_beq & ex_rt_m))) |
                  (mem_ctrl_q[1] & mem_nz & (mem_rs_m | (id_beq & mem_rt_m))));
    raw_haz   = (ex_ctrl_q.reg_write & ex_nz & (ex_rs_m | (id_use_rt & ex_rt_m))) |
                (mem_wb_q[1] & mem_nz & (mem_rs_m | (id_use_rt & mem_rt_m)));
`ifdef PIPE_CTRL_FORWARD_EN
    hz_stall  = load_use | br_haz;
`else
    hz_stall  = load_use | br_haz | raw_haz;
`endif
  end

  // Fetch enables and control transfer; reset, then stalls, take priority.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    if_flush   = 1'b0;
    pc_src     = 1'b0;
    jump       = 1'b0;
    jump_r     = 1'b0;
    if (rst) begin
      pc_write = 1'b0;
    end else if (mul_stall || hz_stall) begin
      ifid_write = 1'b0;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      pc_src     = id_beq & eq;
      jump       = id_jump;
      jump_r     = id_jump_r;
      if_flush   = (id_beq & eq) | id_jump | id_jump_r;
    end
  end

  // Next-state of the stage registers and the multiplier countdown.
  always_comb begin
    ex_ctrl_d  = ex_ctrl_q;
    ex_dst_d   = ex_dst_q;
    mem_ctrl_d = mem_bits(ex_ctrl_q);
    mem_wb_d   = wb_bits(ex_ctrl_q);
    mem_dst_d  = ex_dst_q;
    wb_ctrl_d  = mem_wb_q;
    wb_dst_d   = mem_dst_q;
    mul_cnt_d  = 4'd0;
`ifdef PIPE_CTRL_FORWARD_EN
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
`endif
    if (mul_stall) begin
      // mult keeps EX; a bubble drains into MEM
      mul_cnt_d  = mul_cnt_q - 4'd1;
      mem_ctrl_d = 2'b00;
      mem_wb_d   = 2'b00;
      mem_dst_d  = '0;
    end else if (hz_stall) begin
      ex_ctrl_d = CTRL_ZERO;
      ex_dst_d  = '0;
`ifdef PIPE_CTRL_FORWARD_EN
      ex_rs_d   = '0;
      ex_rt_d   = '0;
`endif
    end else begin
      ex_ctrl_d = id_ctrl;
      ex_dst_d  = id_dst;
      mul_cnt_d = id_ctrl.mul ? MUL_INIT : 4'd0;
`ifdef PIPE_CTRL_FORWARD_EN
      ex_rs_d   = id_rs;
      ex_rt_d   = id_rt;
`endif
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= CTRL_ZERO;
      ex_dst_q   <= '0;
      mem_ctrl_q <= 2'b00;
      mem_wb_q   <= 2'b00;
      mem_dst_q  <= '0;
      wb_ctrl_q  <= 2'b00;
      wb_dst_q   <= '0;
      mul_cnt_q  <= 4'd0;
`ifdef PIPE_CTRL_FORWARD_EN
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
`endif
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dst_q   <= ex_dst_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_wb_q   <= mem_wb_d;
      mem_dst_q  <= mem_dst_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_dst_q   <= wb_dst_d;
      mul_cnt_q  <= mul_cnt_d;
`ifdef PIPE_CTRL_FORWARD_EN
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
`endif
    end
  end

`ifdef PIPE_CTRL_FORWARD_EN
  // Operand forwarding selects for the EX stage; EX/MEM beats MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_wb_q[1] && mem_nz && (mem_dst_q == ex_rs_q)) begin
      fwd_a = 2'b10;
    end else if (wb_ctrl_q[1] && (wb_dst_q != '0) && (wb_dst_q == ex_rs_q)) begin
      fwd_a = 2'b01;
    end else begin
      fwd_a = 2'b00;
    end
    if (mem_wb_q[1] && mem_nz && (mem_dst_q == ex_rt_q)) begin
      fwd_b = 2'b10;
    end else if (wb_ctrl_q[1] && (wb_dst_q != '0) && (wb_dst_q == ex_rt_q)) begin
      fwd_b = 2'b01;
    end else begin
      fwd_b = 2'b00;
    end
  end
`endif

  assign ex_ctrl  = ex_bits(ex_ctrl_q);
  assign mem_ctrl = mem_ctrl_q;
  assign wb_ctrl  = wb_ctrl_q;
  assign ex_dst   = ex_dst_q;
  assign mem_dst  = mem_dst_q;
  assign wb_dst   = wb_dst_q;
  assign mul_busy = mul_stall;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized self-checking bench for pipe_ctrl_unit against a pipeline
// reference model built from instruction slots and source-register lists.
module tb_pipe_ctrl_unit;

  localparam int MUL_LAT = 4;
  localparam int RA_W    = 5;
  localparam int RA_REG  = 31;
  localparam int NCYC    = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] id_op, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       eq;
  logic       pc_write, ifid_write, if_flush, pc_src, jump, jump_r, mul_busy;
  logic [5:0] ex_ctrl;
  logic [1:0] mem_ctrl, wb_ctrl;
  logic [4:0] ex_dst, mem_dst, wb_dst;
`ifdef PIPE_CTRL_FORWARD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  pipe_ctrl_unit #(.MUL_LAT(MUL_LAT), .RA_W(RA_W), .RA_REG(RA_REG)) dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .eq(eq),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .pc_src(pc_src), .jump(jump), .jump_r(jump_r),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .mul_busy(mul_busy)
`ifdef PIPE_CTRL_FORWARD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One instruction as it travels through the reference pipe.
  typedef struct packed {
    logic       reg_dst, alu_src;
    logic [1:0] alu_op;
    logic       ra_write, mul, mem_read, mem_write, reg_write, mem_to_reg;
    logic [4:0] dst, rs, rt;
  } slot_t;

  slot_t m_ex, m_mem, m_wb, dec;
  int    m_cnt;

  function automatic slot_t decode_ref(input logic [5:0] op, input logic [5:0] fn,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd);
    slot_t s;
    s = '0;
    s.rs = rs;
    s.rt = rt;
    case (op)
      6'h00: begin
        s.reg_dst = 1'b1;
        s.alu_op  = 2'b10;
        if (fn == 6'h08) begin
          s.reg_write = 1'b0;
        end else if (fn == 6'h09) begin
          s.ra_write = 1'b1; s.reg_write = 1'b1; s.dst = 5'd31;
        end else if (fn == 6'h18) begin
          s.mul = 1'b1;
        end else begin
          s.reg_write = 1'b1; s.dst = rd;
        end
      end
      6'h04: s.alu_op = 2'b01;
      6'h02: s = s;
      6'h03: begin s.ra_write = 1'b1; s.reg_write = 1'b1; s.dst = 5'd31; end
      6'h23: begin
        s.mem_read = 1'b1; s.mem_to_reg = 1'b1; s.alu_src = 1'b1;
        s.reg_write = 1'b1; s.dst = rt;
      end
      6'h2b: begin s.mem_write = 1'b1; s.alu_src = 1'b1; end
      default: begin
        s.alu_src = 1'b1; s.reg_write = 1'b1; s.alu_op = 2'b11; s.dst = rt;
      end
    endcase
    return s;
  endfunction

  logic [5:0] ops[8];
  logic [5:0] fns[5];
  logic [4:0] srcs[2];
  logic [4:0] bsrc[2];
  int         nsrc, nb;
  logic       is_beq, is_jr, is_j, lu, br, raw, hz, stall, hold;
  logic       e_pw, e_iw, e_fl, e_ps, e_j, e_jr;

  initial begin
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h23, 6'h2b, 6'h08};
    fns = '{6'h20, 6'h08, 6'h09, 6'h18, 6'h22};
    rst = 1'b1; id_op = 6'h00; id_funct = 6'h00;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; eq = 1'b0;
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; hold = 1'b0;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      rst = (i < 2) || ($urandom_range(0, 59) == 0);
      if (!hold) begin
        id_op    = ops[$urandom_range(0, 7)];
        id_funct = fns[$urandom_range(0, 4)];
        id_rs    = 5'($urandom_range(0, 3));
        id_rt    = 5'($urandom_range(0, 3));
        id_rd    = 5'($urandom_range(0, 3));
      end
      eq = 1'($urandom_range(0, 1));
      #1;

      // ID instruction classification and source-register lists
      is_beq = (id_op == 6'h04);
      is_jr  = (id_op == 6'h00) && (id_funct == 6'h08 || id_funct == 6'h09);
      is_j   = (id_op == 6'h02) || (id_op == 6'h03);
      srcs[0] = id_rs; srcs[1] = id_rt; nsrc = 1;
      if (id_op == 6'h00 || is_beq || id_op == 6'h2b) nsrc = 2;
      bsrc[0] = id_rs; bsrc[1] = id_rt;
      nb = is_beq ? 2 : (is_jr ? 1 : 0);

      lu = 1'b0; raw = 1'b0; br = 1'b0;
      for (int k = 0; k < nsrc; k++) begin
        if (srcs[k] != 5'd0) begin
          if (m_ex.mem_read && m_ex.dst == srcs[k]) lu = 1'b1;
          if ((m_ex.reg_write && m_ex.dst == srcs[k]) ||
              (m_mem.reg_write && m_mem.dst == srcs[k])) raw = 1'b1;
        end
      end
      for (int k = 0; k < nb; k++) begin
        if (bsrc[k] != 5'd0) begin
          if ((m_ex.reg_write && m_ex.dst == bsrc[k]) ||
              (m_mem.mem_read && m_mem.dst == bsrc[k])) br = 1'b1;
        end
      end
`ifdef PIPE_CTRL_FORWARD_EN
      hz = lu | br;
`else
      hz = lu | br | raw;
`endif
      stall = (m_cnt > 0) || hz;

      e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b0; e_ps = 1'b0; e_j = 1'b0; e_jr = 1'b0;
      if (!rst && !stall) begin
        e_pw = 1'b1; e_iw = 1'b1;
        e_ps = is_beq && eq; e_j = is_j; e_jr = is_jr;
        e_fl = e_ps | e_j | e_jr;
      end

      check_eq("pc_write",   pc_write,   e_pw);
      check_eq("ifid_write", ifid_write, e_iw);
      check_eq("if_flush",   if_flush,   e_fl);
      check_eq("pc_src",     pc_src,     e_ps);
      check_eq("jump",       jump,       e_j);
      check_eq("jump_r",     jump_r,     e_jr);
      check_eq("mul_busy",   mul_busy,   (m_cnt > 0));
      check_eq("ex_ctrl",    ex_ctrl,    {m_ex.reg_dst, m_ex.alu_src, m_ex.alu_op, m_ex.ra_write, m_ex.mul});
      check_eq("mem_ctrl",   mem_ctrl,   {m_mem.mem_read, m_mem.mem_write});
      check_eq("wb_ctrl",    wb_ctrl,    {m_wb.reg_write, m_wb.mem_to_reg});
      check_eq("ex_dst",     ex_dst,     m_ex.dst);
      check_eq("mem_dst",    mem_dst,    m_mem.dst);
      check_eq("wb_dst",     wb_dst,     m_wb.dst);
`ifdef PIPE_CTRL_FORWARD_EN
      check_eq("fwd_a", fwd_a,
        (m_mem.reg_write && m_mem.dst != 5'd0 && m_mem.dst == m_ex.rs) ? 2'b10 :
        (m_wb.reg_write && m_wb.dst != 5'd0 && m_wb.dst == m_ex.rs) ? 2'b01 : 2'b00);
      check_eq("fwd_b", fwd_b,
        (m_mem.reg_write && m_mem.dst != 5'd0 && m_mem.dst == m_ex.rt) ? 2'b10 :
        (m_wb.reg_write && m_wb.dst != 5'd0 && m_wb.dst == m_ex.rt) ? 2'b01 : 2'b00);
`endif

      // advance the reference pipe to the state after the coming edge
      hold = !rst && stall;
      if (rst) begin
        m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
      end else if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        m_wb  = m_mem;
        m_mem = '0;
      end else if (hz) begin
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = '0;
      end else begin
        dec   = decode_ref(id_op, id_funct, id_rs, id_rt, id_rd);
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = dec;
        m_cnt = dec.mul ? (MUL_LAT - 1) : 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised pipelined control and hazard unit for the 5-stage MIPS core.
- Decodes the ID-stage instruction into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards, and resolves beq/j/jal/jr/jalr in ID with IF flush.
- Sequences a multi-cycle multiplier stall of MUL_LAT cycles.

Parameters:
- MUL_LAT, 4, cycles a mult occupies EX (legal range 1..15).
- RA_W, 5, register-address width.
- RA_REG, 31, destination register written by jal/jalr.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- id_op  in  6  ID instruction[31:26]
- id_funct  in  6  ID instruction[5:0]
- id_rs  in  RA_W  ID rs field
- id_rt  in  RA_W  ID rt field
- id_rd  in  RA_W  ID rd field
- eq  in  1  ID register comparator result
- pc_write  out  1  PC enable
- ifid_write  out  1  IF/ID enable
- if_flush  out  1  zero the IF/ID register
- pc_src  out  1  select branch target
- jump  out  1  select j/jal target
- jump_r  out  1  select register target
- ex_ctrl  out  6  {reg_dst, alu_src, alu_op[1:0], ra_write, mul}
- mem_ctrl  out  2  {mem_read, mem_write}
- wb_ctrl  out  2  {reg_write, mem_to_reg}
- ex_dst, mem_dst, wb_dst  out  RA_W  destination register per stage
- mul_busy  out  1  multiplier occupied

Behaviour:
- Reset: all stage registers, the mul counter and every registered output go to 0. While rst is high, pc_write, ifid_write, if_flush, pc_src, jump and jump_r are driven 0.
- Decode (combinational):
  - R-type: reg_write=1, reg_dst=1, alu_op=2'b10.
  - jr (funct 0x08): jump_r=1, no write.
  - jalr (0x09): jump_r=1, ra_write=1, reg_write=1, dst=RA_REG.
  - mult (0x18): mul=1, no write.
  - beq (0x04): alu_op=2'b01.
  - j (0x02): jump=1.
  - jal (0x03): jump=1, ra_write=1, reg_write=1, dst=RA_REG.
  - lw (0x23): mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, dst=rt.
  - sw (0x2b): mem_write=1, alu_src=1.
  - Default (I-type ALU): alu_src=1, reg_write=1, dst=rt, alu_op=2'b11.
- Stages advance ID->EX->MEM->WB in one cycle each; the bundle is visible at ex_ctrl one cycle after ID.
- Load-use stall: asserted when the EX-stage instruction has mem_read=1, ex_dst!=0, and ex_dst equals id_rs or id_rt (the rt match counts only for R-type, beq and sw). On stall:
  - pc_write=0, ifid_write=0;
  - a zero bundle is loaded into ID/EX;
  - the stall lasts exactly 1 cycle.
- Branch/jr operand stall: asserted when a beq/jr/jalr in ID reads a register that matches a nonzero dst with reg_write=1 in EX, or with mem_read=1 in MEM. Behaviour is the same as a load-use stall and repeats until clear.
- Control transfer, evaluated only when no stall is active:
  - beq with eq=1: pc_src=1, if_flush=1.
  - j/jal: jump=1, if_flush=1.
  - jr/jalr: jump_r=1, if_flush=1.
  - beq with eq=0: no flush.
  - A stall always forces pc_src, jump, jump_r and if_flush to 0.
- Multiplier:
  - When mult enters EX, the counter loads MUL_LAT-1 and mul_busy=1.
  - While the counter is nonzero: it decrements; pc_write=0, ifid_write=0; ID/EX holds its value (not bubbled); EX/MEM receives a zero bundle.
  - MUL_LAT=1 gives no stall.
  - A mult in ID while mul_busy=1 waits.
- Priority: rst > mul stall > hazard stall > control transfer.
- A bubble or flush never sets reg_write or mem_write.
- rst asserted mid-stall or mid-mult clears everything on the next edge.

Optional Feature:
- PIPE_CTRL_FORWARD_EN, when defined:
  - Adds outputs fwd_a[1:0] and fwd_b[1:0] (00 = reg file, 10 = EX/MEM, 01 = MEM/WB; EX/MEM wins).
  - Stalls only on load-use and branch hazards.
- When undefined:
  - There are no forwarding ports.
  - Any RAW match between the ID sources and a nonzero reg_write dst in EX or MEM stalls ID until clear.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode and funct constants;
  - alu_op encodings;
  - a packed ctrl_bundle_t typedef and its zero constant.
- Sub-module ctrl_decode holds the pure combinational ID decoder, instantiated once.

Test Plan:
- lw $2 followed by add $3,$2,$4 -> 1 cycle with pc_write=0 and ifid_write=0, ex_ctrl all zeros in the next cycle, then the add proceeds.
- beq with eq=1 and no hazard -> pc_src=1 and if_flush=1 for 1 cycle; with eq=0 -> both stay 0.
- jal -> jump=1 and if_flush=1; ex_dst=31 and wb_ctrl reg_write=1 three cycles later.
- mult with MUL_LAT=4 -> mul_busy high for 3 cycles, pc_write=0 for 3 cycles, EX/MEM bubbles, then normal flow.
- add $5 followed by jr $5 -> at least 1 stall cycle with jump_r held 0, then jump_r=1 and if_flush=1.
- rst asserted during a mult stall -> the cycle after, mul_busy=0, all ctrl outputs 0; after release pc_write=1.
